rr_mux_arbiter: RTL

//   Controller that shares one N:1 data mux and a single output register among N_REQ

---
 rtl/rr_mux_pkg.sv | 22 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_mux_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// ----------------------------------------------------------------------------
// rr_mux_pkg
//   Shared types and helpers for the round-robin mux arbiter.
//   - arb_state_t : two-state controller encoding (IDLE = output stage empty,
//                   HOLD = output stage holds a word waiting for downstream).
//   - next_ptr    : advance a round-robin pointer by one with an explicit wrap
//                   to zero, so non-power-of-two requester counts never need a
//                   modulo operator.
// ----------------------------------------------------------------------------
package rr_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Pointer following 'ptr' in a ring of 'n' entries; the last slot wraps to 0.
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating priority encoder. Searches i_req starting at index
//   i_ptr, then i_ptr+1, ... N_REQ-1, 0, ... and reports the first set bit.
// Ports
//   i_req      [N_REQ]  request vector
//   i_ptr      [SEL_W]  highest-priority index (always < N_REQ)
//   o_gnt_idx  [SEL_W]  index of the winning request (0 when none)
//   o_any      1        at least one request bit is set
// ----------------------------------------------------------------------------
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_any
);

  int w_cand;

  // Walk the ring once from i_ptr. Because i_ptr < N_REQ, the candidate index
  // never exceeds 2*N_REQ-2, so one conditional subtract folds it back into
  // range without a modulo. The first hit latches via o_any.
  always_comb begin
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_cand    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_REQ) begin
        w_cand = w_cand - N_REQ;
      end
      if (!o_any && i_req[w_cand]) begin
        o_any     = 1'b1;
        o_gnt_idx = SEL_W'(w_cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
//   Shares one N:1 data mux and a single output register among N_REQ
//   valid/ready requesters. A round-robin grant drives the mux select and the
//   chosen word is captured into a 1-entry output stage. Under continuous
//   demand a new word is loaded in the same cycle the held one is accepted,
//   giving one word per cycle.
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous, active-low reset
//   i_req_valid  [N_REQ]        per-requester valid
//   i_req_data   [N_REQ*WIDTH]  requester i at bits [i*WIDTH +: WIDTH]
//   o_req_ready  [N_REQ]        per-requester accept, at most one bit high
//   o_out_valid  1              output stage holds a word
//   o_out_data   [WIDTH]        held word
//   o_out_sel    [SEL_W]        index of the requester whose word is held
//   i_out_ready  1              downstream accept
// ----------------------------------------------------------------------------
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_out_valid,
  output logic [WIDTH-1:0]       o_out_data,
  output logic [SEL_W-1:0]       o_out_sel,
  input  logic                   i_out_ready
);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_any;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  // Rotating priority search starting at the current round-robin pointer.
  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // N:1 data mux steered by the grant. Written as a compare loop so a
  // non-power-of-two N_REQ never produces an out-of-range slice.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_mux_data = i_req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. A transfer always lands in HOLD (including the
  // back-to-back case); a held word that is accepted with nothing new to
  // load empties the stage.
  always_comb begin
    w_next_state = r_state;
    if (w_xfer) begin
      w_next_state = HOLD;
    end else if ((r_state == HOLD) && i_out_ready) begin
      w_next_state = IDLE;
    end
  end

  // Output / handshake logic. The stage can load when it is empty or when
  // its current word leaves this cycle. Reset gates the transfer so no
  // requester sees ready while reset is asserted, even before the state
  // register has a known value.
  always_comb begin
    o_out_valid = (r_state == HOLD);
    w_load      = (r_state == IDLE) | (i_out_ready & o_out_valid);
    w_xfer      = w_load & w_any & i_rst;
    o_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_xfer && (w_gnt_idx == SEL_W'(i))) begin
        o_req_ready[i] = 1'b1;
      end
    end
  end

  // Output register and round-robin pointer. Both only move on a transfer;
  // the pointer lands one past the served requester so it becomes lowest
  // priority next time.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_xfer) begin
      r_out_data <= w_mux_data;
      r_out_sel  <= w_gnt_idx;
      r_rr_ptr   <= SEL_W'(next_ptr(int'(w_gnt_idx), N_REQ));
    end
  end

  assign o_out_data = r_out_data;
  assign o_out_sel  = r_out_sel;

  // Structural invariants of the handshake.
  a_ready_onehot: assert property (@(posedge i_clk) $onehot0(o_req_ready));

  a_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst)
    int'(r_rr_ptr) < N_REQ);

  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst)
    (o_out_valid && !i_out_ready) |=>
      (o_out_valid && $stable(o_out_data) && $stable(o_out_sel)));

endmodule : rr_mux_arbiter
